// File: rtl/rocket_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : rocket_reset_seq
// Purpose  : Reset sequencer for the Rocket subsystem. Synchronizes release
//            of the async system reset, holds the uncore in reset for
//            HOLD_CYCLES, then releases tile resets STAGGER cycles apart.
//            Supports software re-reset from RELEASE/RUN.
// Options  : ROCKET_RESET_SEQ_WDT_EN - enables the RUN-state watchdog that
//            triggers a re-reset and sets the sticky wdt_fired flag.
// Revision : 1.0 - initial release
// ============================================================================
module rocket_reset_seq #(
  parameter int N_TILES     = 4,
  parameter int HOLD_CYCLES = 100,
  parameter int STAGGER     = 16,
  parameter int WDT_CYCLES  = 1000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sw_reset_req,
  input  logic               wdt_kick,
  output logic               sys_reset,
  output logic [N_TILES-1:0] tile_reset,
  output logic               ready,
  output logic               wdt_fired
);

  // Counter must hold the largest terminal value of any state that uses it.
  localparam int c_rel_cycles = STAGGER * N_TILES;
  localparam int c_max_a      = (HOLD_CYCLES > c_rel_cycles) ? HOLD_CYCLES : c_rel_cycles;
  localparam int c_cnt_max    = (c_max_a > WDT_CYCLES) ? c_max_a : WDT_CYCLES;
  localparam int c_cnt_w      = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rel_last  = c_cnt_w'(c_rel_cycles - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic               r_sync_d;
  logic               r_sync_q;
  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sys_reset;
  logic [N_TILES-1:0] r_tile_reset;
  logic               r_ready;
  logic               w_wdt_timeout;
  logic               w_rereset;

`ifdef ROCKET_RESET_SEQ_WDT_EN
  localparam logic [c_cnt_w-1:0] c_wdt_last = c_cnt_w'(WDT_CYCLES - 1);
  logic r_wdt_fired;

  // Timeout fires only when no kick arrives on the terminal count cycle.
  assign w_wdt_timeout = (r_state == ST_RUN) && !wdt_kick && (r_cnt == c_wdt_last);

  // Sticky flag recording that the watchdog forced a re-reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdt_fired <= 1'b0;
    end else if (w_wdt_timeout) begin
      r_wdt_fired <= 1'b1;
    end
  end

  assign wdt_fired = r_wdt_fired;
`else
  logic w_unused_kick;
  assign w_unused_kick = wdt_kick;
  assign w_wdt_timeout = 1'b0;
  assign wdt_fired     = 1'b0;
`endif

  // A watchdog timeout behaves exactly like a software request.
  assign w_rereset = sw_reset_req || w_wdt_timeout;

  // Two-flop synchronizer for the deassertion edge of reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_d <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync_d <= 1'b1;
      r_sync_q <= r_sync_d;
    end
  end

  // Sequencer FSM; every output is a flop driven from here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_SYNC;
      r_cnt        <= '0;
      r_sys_reset  <= 1'b1;
      r_tile_reset <= '1;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        ST_SYNC: begin
          if (r_sync_q) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end
        end

        // Re-reset requests are deliberately ignored while holding.
        ST_HOLD: begin
          if (r_cnt == c_hold_last) begin
            r_sys_reset <= 1'b0;
            r_state     <= ST_RELEASE;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        // A request on a release cycle wins, so no tile drops that cycle.
        ST_RELEASE: begin
          if (w_rereset) begin
            r_sys_reset  <= 1'b1;
            r_tile_reset <= '1;
            r_ready      <= 1'b0;
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
            for (int i = 0; i < N_TILES; i++) begin
              if (r_cnt == c_cnt_w'(STAGGER * (i + 1) - 1)) begin
                r_tile_reset[i] <= 1'b0;
              end
            end
            if (r_cnt == c_rel_last) begin
              r_ready <= 1'b1;
              r_state <= ST_RUN;
              r_cnt   <= '0;
            end
          end
        end

        // In RUN the counter only advances when the watchdog is built in.
        ST_RUN: begin
          if (w_rereset) begin
            r_sys_reset  <= 1'b1;
            r_tile_reset <= '1;
            r_ready      <= 1'b0;
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
          end else begin
`ifdef ROCKET_RESET_SEQ_WDT_EN
            if (wdt_kick) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
`else
            r_cnt <= '0;
`endif
          end
        end

        default: begin
          r_state <= ST_SYNC;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sys_reset  = r_sys_reset;
  assign tile_reset = r_tile_reset;
  assign ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_rocket_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rocket_reset_seq
// Purpose  : Directed self-checking bench for rocket_reset_seq with default
//            parameters. Watchdog scenarios are compiled in only when
//            ROCKET_RESET_SEQ_WDT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rocket_reset_seq;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       sys_reset;
  logic [3:0] tile_reset;
  logic       ready;
  logic       wdt_fired;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  rocket_reset_seq #(
    .N_TILES    (4),
    .HOLD_CYCLES(100),
    .STAGGER    (16),
    .WDT_CYCLES (1000)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sw_reset_req(sw_reset_req),
    .wdt_kick    (wdt_kick),
    .sys_reset   (sys_reset),
    .tile_reset  (tile_reset),
    .ready       (ready),
    .wdt_fired   (wdt_fired)
  );

  always #5 clock = ~clock;

  // Edge number: edge 1 is the first rising edge with reset_n high.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after edge n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic restart();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while reset_n is low.
    repeat (3) @(posedge clock);
    #1;
    check("rst_sys", sys_reset, 1);
    check("rst_tile", tile_reset, 4'hF);
    check("rst_ready", ready, 0);
    check("rst_wdt", wdt_fired, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Nominal sequence.
    goto(102); check("s1_sys_102", sys_reset, 1);
    goto(103); check("s1_sys_103", sys_reset, 0);
               check("s1_tile_103", tile_reset, 4'hF);
    goto(118); check("s1_tile_118", tile_reset, 4'hF);
    goto(119); check("s1_tile_119", tile_reset, 4'hE);
    goto(135); check("s1_tile_135", tile_reset, 4'hC);
    goto(151); check("s1_tile_151", tile_reset, 4'h8);
    goto(166); check("s1_tile_166", tile_reset, 4'h8);
               check("s1_ready_166", ready, 0);
    goto(167); check("s1_tile_167", tile_reset, 4'h0);
               check("s1_ready_167", ready, 1);

    // Software re-reset pulse in RUN.
    goto(200); sw_reset_req = 1'b1;
    goto(201); sw_reset_req = 1'b0;
    check("sw_sys_201", sys_reset, 1);
    check("sw_tile_201", tile_reset, 4'hF);
    check("sw_ready_201", ready, 0);
    goto(300); check("sw_sys_300", sys_reset, 1);
    goto(301); check("sw_sys_301", sys_reset, 0);
    goto(364); check("sw_ready_364", ready, 0);
               check("sw_tile_364", tile_reset, 4'h8);
    goto(365); check("sw_ready_365", ready, 1);
               check("sw_tile_365", tile_reset, 4'h0);
    check("sw_wdt", wdt_fired, 0);

    // Request held during HOLD is ignored.
    restart();
    goto(10); sw_reset_req = 1'b1;
    goto(50); sw_reset_req = 1'b0;
    check("hold_sys_50", sys_reset, 1);
    goto(102); check("hold_sys_102", sys_reset, 1);
    goto(103); check("hold_sys_103", sys_reset, 0);
    goto(119); check("hold_tile_119", tile_reset, 4'hE);
    goto(130); check("hold_tile_130", tile_reset, 4'hE);

    // Asynchronous abort mid-RELEASE.
    reset_n = 1'b0;
    #1;
    check("abort_sys", sys_reset, 1);
    check("abort_tile", tile_reset, 4'hF);
    check("abort_ready", ready, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Restarted sequence, then request on the last-tile release cycle.
    goto(102); check("rs_sys_102", sys_reset, 1);
    goto(103); check("rs_sys_103", sys_reset, 0);
    goto(119); check("rs_tile_119", tile_reset, 4'hE);
    goto(166); check("rs_ready_166", ready, 0);
               check("rs_tile_166", tile_reset, 4'h8);
    sw_reset_req = 1'b1;
    goto(167); sw_reset_req = 1'b0;
    check("race_sys_167", sys_reset, 1);
    check("race_tile_167", tile_reset, 4'hF);
    check("race_ready_167", ready, 0);
    goto(266); check("race_sys_266", sys_reset, 1);
    goto(267); check("race_sys_267", sys_reset, 0);
    check("race_wdt", wdt_fired, 0);

`ifdef ROCKET_RESET_SEQ_WDT_EN
    // No kicks: timeout re-reset at edge 1167.
    restart();
    goto(167);  check("wdt_ready_167", ready, 1);
                check("wdt_flag_167", wdt_fired, 0);
    goto(1166); check("wdt_ready_1166", ready, 1);
                check("wdt_sys_1166", sys_reset, 0);
    goto(1167); check("wdt_sys_1167", sys_reset, 1);
                check("wdt_ready_1167", ready, 0);
                check("wdt_flag_1167", wdt_fired, 1);
    goto(1300); check("wdt_flag_sticky", wdt_fired, 1);

    // Regular kicks keep RUN alive.
    restart();
    check("kick_flag_clr", wdt_fired, 0);
    for (int e = 600; e <= 2100; e += 500) begin
      goto(e);   wdt_kick = 1'b1;
      goto(e+1); wdt_kick = 1'b0;
    end
    goto(2200); check("kick_ready_2200", ready, 1);
                check("kick_sys_2200", sys_reset, 0);
                check("kick_flag_2200", wdt_fired, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
